// File: rtl/data_sync_pkg.sv
// Shared constants for the multi-channel enable-synchronised data capture block.
package data_sync_pkg;

    localparam int MODE_LEVEL  = 32'd0;
    localparam int MODE_TOGGLE = 32'd1;

    localparam int MIN_STAGES  = 32'd2;
    localparam int MAX_STAGES  = 32'd4;

endpackage

// File: rtl/data_sync_ch.sv
// One channel: enable synchroniser, edge detect, data capture register and
// valid/overrun bookkeeping. Data is captured directly, only the enable is synced.
module data_sync_ch
    import data_sync_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_STAGES  = 2,
    parameter int ENABLE_MODE = MODE_LEVEL
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  bus_enable_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  ready_i,
    input  logic                  overrun_clr_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  enable_pulse_o,
    output logic                  valid_o,
    output logic                  overrun_o
);

    logic [NUM_STAGES-1:0] sync_q;
    logic                  hist_q;
    logic                  evt_s;
    logic                  evt_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  pulse_q;
    logic                  valid_q;
    logic                  valid_d;
    logic                  ovr_q;
    logic                  ovr_d;

    // Edge detect on the last synchroniser stage against its history flop.
    always_comb begin
        evt_s = 1'b0;
        if (ENABLE_MODE == MODE_TOGGLE) begin
            evt_s = sync_q[NUM_STAGES-1] ^ hist_q;
        end else begin
            evt_s = sync_q[NUM_STAGES-1] & ~hist_q;
        end
    end

    // Capture, valid and overrun next state; an overrun set beats a clear.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (evt_q) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (evt_q && valid_q && !ready_i) begin
            ovr_d = 1'b1;
        end else if (overrun_clr_i) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // State registers; reset wipes pending events so nothing fires after release.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q  <= {NUM_STAGES{1'b0}};
            hist_q  <= 1'b0;
            evt_q   <= 1'b0;
            data_q  <= {DATA_WIDTH{1'b0}};
            pulse_q <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[NUM_STAGES-2:0], bus_enable_i};
            hist_q  <= sync_q[NUM_STAGES-1];
            evt_q   <= evt_s;
            data_q  <= data_d;
            pulse_q <= evt_q;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o         = data_q;
    assign enable_pulse_o = pulse_q;
    assign valid_o        = valid_q;
    assign overrun_o      = ovr_q;

endmodule

// File: rtl/data_sync_multi.sv
// Array of independent enable-synchronised capture channels sharing one
// destination clock; channel i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
module data_sync_multi
    import data_sync_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_CH      = 4,
    parameter int NUM_STAGES  = 2,
    parameter int ENABLE_MODE = MODE_LEVEL
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_CH-1:0]            bus_enable,
    input  logic [NUM_CH*DATA_WIDTH-1:0] unsync_bus,
    output logic [NUM_CH*DATA_WIDTH-1:0] sync_bus,
    output logic [NUM_CH-1:0]            enable_pulse,
    output logic [NUM_CH-1:0]            valid,
    input  logic [NUM_CH-1:0]            ready,
    output logic [NUM_CH-1:0]            overrun,
    input  logic [NUM_CH-1:0]            overrun_clr
);

    if (NUM_STAGES < MIN_STAGES || NUM_STAGES > MAX_STAGES) begin : g_bad_stages
        $error("data_sync_multi: NUM_STAGES must be within 2..4");
    end
    if (ENABLE_MODE != MODE_LEVEL && ENABLE_MODE != MODE_TOGGLE) begin : g_bad_mode
        $error("data_sync_multi: ENABLE_MODE must be 0 (LEVEL) or 1 (TOGGLE)");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_ch
        $error("data_sync_multi: NUM_CH must be within 1..16");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        data_sync_ch #(
            .DATA_WIDTH  (DATA_WIDTH),
            .NUM_STAGES  (NUM_STAGES),
            .ENABLE_MODE (ENABLE_MODE)
        ) u_ch (
            .clk_i          (CLK),
            .rst_n_i        (RST),
            .bus_enable_i   (bus_enable[i]),
            .data_i         (unsync_bus[i*DATA_WIDTH +: DATA_WIDTH]),
            .ready_i        (ready[i]),
            .overrun_clr_i  (overrun_clr[i]),
            .data_o         (sync_bus[i*DATA_WIDTH +: DATA_WIDTH]),
            .enable_pulse_o (enable_pulse[i]),
            .valid_o        (valid[i]),
            .overrun_o      (overrun[i])
        );
    end

endmodule

// File: tb/tb_data_sync_multi.sv
// Scoreboard bench: three configurations (LEVEL/2 stages, TOGGLE/2 stages,
// LEVEL/3 stages); expected captures are queued at stimulus time and popped on pulses.
module tb_data_sync_multi;
    import data_sync_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [3:0]  be   [3];
    logic [31:0] ub   [3];
    logic [3:0]  rdy  [3];
    logic [3:0]  oclr [3];
    logic [31:0] sb   [3];
    logic [3:0]  ep   [3];
    logic [3:0]  vl   [3];
    logic [3:0]  ov   [3];

    int cyc  = 0;
    int chk  = 0;
    int errs = 0;

    typedef struct {
        int         inst;
        int         ch;
        int         cyc;
        logic [7:0] data;
        logic       v;
        logic       ov;
    } exp_t;
    exp_t q[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    data_sync_multi #(.DATA_WIDTH(8), .NUM_CH(4), .NUM_STAGES(2), .ENABLE_MODE(MODE_LEVEL)) u_lvl (
        .CLK(CLK), .RST(RST), .bus_enable(be[0]), .unsync_bus(ub[0]), .sync_bus(sb[0]),
        .enable_pulse(ep[0]), .valid(vl[0]), .ready(rdy[0]), .overrun(ov[0]), .overrun_clr(oclr[0]));
    data_sync_multi #(.DATA_WIDTH(8), .NUM_CH(4), .NUM_STAGES(2), .ENABLE_MODE(MODE_TOGGLE)) u_tgl (
        .CLK(CLK), .RST(RST), .bus_enable(be[1]), .unsync_bus(ub[1]), .sync_bus(sb[1]),
        .enable_pulse(ep[1]), .valid(vl[1]), .ready(rdy[1]), .overrun(ov[1]), .overrun_clr(oclr[1]));
    data_sync_multi #(.DATA_WIDTH(8), .NUM_CH(4), .NUM_STAGES(3), .ENABLE_MODE(MODE_LEVEL)) u_n3 (
        .CLK(CLK), .RST(RST), .bus_enable(be[2]), .unsync_bus(ub[2]), .sync_bus(sb[2]),
        .enable_pulse(ep[2]), .valid(vl[2]), .ready(rdy[2]), .overrun(ov[2]), .overrun_clr(oclr[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_sync_bus_%0d", tag, i), sb[i], 32'h0);
            check($sformatf("%s_pulse_%0d", tag, i), {28'h0, ep[i]}, 32'h0);
            check($sformatf("%s_valid_%0d", tag, i), {28'h0, vl[i]}, 32'h0);
            check($sformatf("%s_overrun_%0d", tag, i), {28'h0, ov[i]}, 32'h0);
        end
    endtask

    // Drive one channel enable/data and queue the capture expected NUM_STAGES+1 edges after first sampling.
    task automatic fire(input int inst, input int ch, input logic lvl, input logic [7:0] d,
                        input logic exp_ov, input int n, output int e);
        ub[inst][ch*8 +: 8] = d;
        be[inst][ch]        = lvl;
        e = cyc + n + 2;
        q.push_back('{inst, ch, e, d, 1'b1, exp_ov});
    endtask

    task automatic wait_edge(input int target);
        while (cyc < target) @(negedge CLK);
    endtask

    // Monitor: every pulse must match the oldest queued expectation for that channel.
    always @(negedge CLK) begin
        if (RST === 1'b1) begin
            for (int i = 0; i < 3; i++) begin
                for (int c = 0; c < 4; c++) begin
                    if (ep[i][c] === 1'b1) begin
                        int idx;
                        idx = -1;
                        foreach (q[k]) if (idx < 0 && q[k].inst == i && q[k].ch == c) idx = k;
                        if (idx < 0) begin
                            chk++;
                            errs++;
                            $display("FAIL unexpected_pulse inst%0d ch%0d: got pulse at edge %0d, expected none", i, c, cyc);
                        end else begin
                            check($sformatf("pulse_edge_i%0d_c%0d", i, c), cyc, q[idx].cyc);
                            check($sformatf("sync_data_i%0d_c%0d", i, c), {24'h0, sb[i][c*8 +: 8]}, {24'h0, q[idx].data});
                            check($sformatf("valid_i%0d_c%0d", i, c), {31'h0, vl[i][c]}, {31'h0, q[idx].v});
                            check($sformatf("overrun_i%0d_c%0d", i, c), {31'h0, ov[i][c]}, {31'h0, q[idx].ov});
                            q.delete(idx);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int e;
        for (int i = 0; i < 3; i++) begin
            be[i] = 4'h0; ub[i] = 32'h0; rdy[i] = 4'h0; oclr[i] = 4'h0;
        end
        repeat (3) @(negedge CLK);
        check_zero("reset");
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // LEVEL rise on ch0, then data must hold through a falling enable
        fire(0, 0, 1'b1, 8'hA5, 1'b0, 2, e);
        repeat (8) @(negedge CLK);
        ub[0][7:0] = 8'h5A;
        be[0][0]   = 1'b0;
        repeat (5) @(negedge CLK);
        check("hold_ch0", {24'h0, sb[0][7:0]}, 32'hA5);

        // ch2 overrun with ready low, then clear, then set-wins-over-clear
        fire(0, 2, 1'b1, 8'h11, 1'b0, 2, e);
        repeat (6) @(negedge CLK);
        be[0][2] = 1'b0;
        repeat (4) @(negedge CLK);
        fire(0, 2, 1'b1, 8'h22, 1'b1, 2, e);
        repeat (6) @(negedge CLK);
        check("ovr_ch2_set", {31'h0, ov[0][2]}, 32'h1);
        oclr[0][2] = 1'b1;
        @(negedge CLK);
        oclr[0][2] = 1'b0;
        check("ovr_ch2_clr", {31'h0, ov[0][2]}, 32'h0);
        check("valid_ch2_kept", {31'h0, vl[0][2]}, 32'h1);
        be[0][2] = 1'b0;
        repeat (4) @(negedge CLK);
        fire(0, 2, 1'b1, 8'h33, 1'b1, 2, e);
        wait_edge(e - 1);
        oclr[0][2] = 1'b1;
        @(negedge CLK);
        oclr[0][2] = 1'b0;
        repeat (3) @(negedge CLK);
        check("ovr_ch2_setwins", {31'h0, ov[0][2]}, 32'h1);

        // ch3 capture coinciding with valid && ready: no overrun
        fire(0, 3, 1'b1, 8'h55, 1'b0, 2, e);
        repeat (6) @(negedge CLK);
        be[0][3] = 1'b0;
        repeat (4) @(negedge CLK);
        fire(0, 3, 1'b1, 8'h66, 1'b0, 2, e);
        wait_edge(e - 1);
        rdy[0][3] = 1'b1;
        @(negedge CLK);
        rdy[0][3] = 1'b0;
        repeat (2) @(negedge CLK);
        check("valid_ch3_kept", {31'h0, vl[0][3]}, 32'h1);
        rdy[0][3] = 1'b1;
        @(negedge CLK);
        rdy[0][3] = 1'b0;
        check("valid_ch3_clr", {31'h0, vl[0][3]}, 32'h0);
        check("data_ch3_hold", {24'h0, sb[0][31:24]}, 32'h66);

        // TOGGLE: rise then fall 20 cycles apart, second capture overruns
        fire(1, 1, 1'b1, 8'h3C, 1'b0, 2, e);
        repeat (20) @(negedge CLK);
        fire(1, 1, 1'b0, 8'hC3, 1'b1, 2, e);
        repeat (8) @(negedge CLK);

        // Three stages: all four channels enabled on the same edge
        ub[2] = 32'h4030_2010;
        be[2] = 4'hF;
        for (int c = 0; c < 4; c++) begin
            logic [7:0] d;
            d = ub[2][c*8 +: 8];
            q.push_back('{2, c, cyc + 5, d, 1'b1, 1'b0});
        end
        repeat (10) @(negedge CLK);

        // Reset one cycle before an expected pulse on LEVEL ch1
        ub[0][15:8] = 8'h77;
        be[0][1]    = 1'b1;
        e = cyc + 4;
        wait_edge(e - 1);
        RST = 1'b0;
        #1;
        check_zero("midrst");
        for (int i = 0; i < 3; i++) be[i] = 4'h0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (10) @(negedge CLK);
        check("post_rst_valid", {28'h0, vl[0]}, 32'h0);
        check("post_rst_data", sb[0], 32'h0);

        check("queue_empty", q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", chk, errs);
        $finish;
    end

endmodule
